// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Brief    : Loopback checker for a multiplexed 4-digit 7-segment bus; recovers
//            the rotating circle-marker position, step direction and errors.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anodes,
  input  logic [7:0]  cathodes,
  output logic [2:0]  pos,
  output logic        pos_valid,
  output logic        step,
  output logic        dir_cw,
  output logic        blank,
  output logic        err,
  output logic [7:0]  err_count,
  output logic [31:0] seg_frame
);

  localparam logic [7:0] C_SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [7:0] C_TOP    = 8'hA3;
  localparam logic [7:0] C_BOT    = 8'h9C;

  localparam logic [1:0] S_BLANK = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  logic [11:0] r_sync1;
  logic [11:0] r_sync2;
  logic [11:0] r_prev;
  logic [7:0]  r_cnt;
  logic [1:0]  r_state;

  logic        w_accept;
  logic [3:0]  w_a;
  logic [7:0]  w_c;
  logic        w_onehot;
  logic [1:0]  w_d;
  logic        w_blank_pat;
  logic        w_pos_pat;
  logic [2:0]  w_p;
  logic        w_fwd;
  logic        w_back;
  logic        w_err_ev;

  always_comb begin
    w_a         = r_sync2[11:8];
    w_c         = r_sync2[7:0];
    // cnt reaches SETTLE-1 once per stable run, then parks at SETTLE
    w_accept    = (r_sync2 == r_prev) && (r_cnt == C_SETTLE - 8'd1);
    w_onehot    = 1'b1;
    w_d         = 2'd0;
    case (w_a)
      4'b0111: w_d = 2'd0;
      4'b1011: w_d = 2'd1;
      4'b1101: w_d = 2'd2;
      4'b1110: w_d = 2'd3;
      default: w_onehot = 1'b0;
    endcase
    w_blank_pat = (w_a == 4'hF);
    w_pos_pat   = w_onehot && ((w_c == C_TOP) || (w_c == C_BOT));
    w_p         = (w_c == C_TOP) ? {1'b0, w_d} : (3'd7 - {1'b0, w_d});
    w_fwd       = (w_p == pos + 3'd1);
    w_back      = (w_p == pos - 3'd1);
    w_err_ev    = w_accept && !w_blank_pat &&
                  (!w_pos_pat ||
                   ((r_state == S_TRACK) && (w_p != pos) && !w_fwd && !w_back));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_cnt   <= C_SETTLE;
    end else begin
      r_sync1 <= {anodes, cathodes};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_sync2 != r_prev) begin
        r_cnt <= 8'd0;
      end else if (r_cnt < C_SETTLE) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_BLANK;
      pos       <= 3'd0;
      pos_valid <= 1'b0;
      step      <= 1'b0;
      dir_cw    <= 1'b1;
      blank     <= 1'b1;
      err       <= 1'b0;
      err_count <= 8'd0;
      seg_frame <= 32'hFFFF_FFFF;
    end else begin
      step <= 1'b0;
      err  <= w_err_ev;
      if (w_err_ev && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      if (w_accept) begin
        // Illegal cathodes on a single lit digit are still captured
        if (w_onehot) begin
          case (w_d)
            2'd0:    seg_frame[31:24] <= w_c;
            2'd1:    seg_frame[23:16] <= w_c;
            2'd2:    seg_frame[15:8]  <= w_c;
            default: seg_frame[7:0]   <= w_c;
          endcase
        end
        if (w_blank_pat) begin
          r_state   <= S_BLANK;
          blank     <= 1'b1;
          pos_valid <= 1'b0;
        end else if (!w_pos_pat) begin
          r_state   <= S_ERROR;
          blank     <= 1'b0;
          pos_valid <= 1'b0;
        end else if (r_state != S_TRACK) begin
          r_state   <= S_TRACK;
          pos       <= w_p;
          pos_valid <= 1'b1;
          blank     <= 1'b0;
        end else if (w_p == pos) begin
          pos <= pos;
        end else if (w_fwd) begin
          step   <= 1'b1;
          dir_cw <= 1'b1;
          pos    <= w_p;
        end else if (w_back) begin
          step   <= 1'b1;
          dir_cw <= 1'b0;
          pos    <= w_p;
        end else begin
          pos <= w_p;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_decoder
// Brief    : Directed self-checking bench for seg_scan_decoder (SETTLE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  anodes = 4'hF;
  logic [7:0]  cathodes = 8'hFF;
  logic [2:0]  pos;
  logic        pos_valid, step, dir_cw, blank, err;
  logic [7:0]  err_count;
  logic [31:0] seg_frame;

  int n_vec = 0;
  int n_bad = 0;
  int n_step = 0;
  int n_errp = 0;
  logic [31:0] exp_frame = 32'hFFFF_FFFF;

  seg_scan_decoder #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .anodes(anodes), .cathodes(cathodes),
    .pos(pos), .pos_valid(pos_valid), .step(step), .dir_cw(dir_cw),
    .blank(blank), .err(err), .err_count(err_count), .seg_frame(seg_frame)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step === 1'b1) n_step++;
    if (err === 1'b1) n_errp++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pat(input int p);
    int d;
    logic [3:0] a;
    d = (p < 4) ? p : 7 - p;
    a = ~(4'b1000 >> d);
    return {a, (p < 4) ? 8'hA3 : 8'h9C};
  endfunction

  // Drive marker position p and check 6 quiet edges, then the update on edge 7
  task automatic move(input int p, input logic [2:0] old_pos, input logic old_valid,
                      input logic e_step, input logic e_dir, input logic e_err,
                      input string tag);
    int d;
    {anodes, cathodes} = pat(p);
    edges(6);
    chk({tag, " hold pos"}, {29'd0, pos}, {29'd0, old_pos});
    chk({tag, " hold valid"}, {31'd0, pos_valid}, {31'd0, old_valid});
    edges(1);
    d = (p < 4) ? p : 7 - p;
    exp_frame[8*(3-d) +: 8] = (p < 4) ? 8'hA3 : 8'h9C;
    chk({tag, " pos"}, {29'd0, pos}, p);
    chk({tag, " valid"}, {31'd0, pos_valid}, 32'd1);
    chk({tag, " step"}, {31'd0, step}, {31'd0, e_step});
    chk({tag, " dir"}, {31'd0, dir_cw}, {31'd0, e_dir});
    chk({tag, " err"}, {31'd0, err}, {31'd0, e_err});
    chk({tag, " blank"}, {31'd0, blank}, 32'd0);
    chk({tag, " frame"}, seg_frame, exp_frame);
    edges(1);
    chk({tag, " step off"}, {31'd0, step}, 32'd0);
    edges(2);
  endtask

  initial begin
    int b_s, b_e;
    edges(3);
    chk("rst pos", {29'd0, pos}, 32'd0);
    chk("rst valid", {31'd0, pos_valid}, 32'd0);
    chk("rst dir", {31'd0, dir_cw}, 32'd1);
    chk("rst blank", {31'd0, blank}, 32'd1);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst errcnt", {24'd0, err_count}, 32'd0);
    chk("rst frame", seg_frame, 32'hFFFF_FFFF);
    rst = 1'b0;
    edges(2);

    // clockwise sweep 0..7,0
    b_s = n_step;
    move(0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, "cw0");
    for (int p = 1; p < 8; p++) move(p, 3'(p - 1), 1'b1, 1'b1, 1'b1, 1'b0, "cw");
    move(0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, "cw wrap");
    chk("cw steps", n_step - b_s, 32'd8);

    // counter-clockwise 3,2,1,0,7
    move(1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "pre1");
    move(2, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "pre2");
    move(3, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, "pre3");
    b_s = n_step;
    move(2, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, "ccw2");
    move(1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, "ccw1");
    move(0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, "ccw0");
    move(7, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, "ccw wrap");
    chk("ccw steps", n_step - b_s, 32'd4);

    // glitch rejection at pos 2
    move(0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, "g0");
    move(1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "g1");
    move(2, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "g2");
    b_s = n_step;
    b_e = n_errp;
    anodes = 4'b1110; cathodes = 8'hA3;
    edges(4);
    anodes = 4'b0000; cathodes = 8'h00;
    edges(1);
    {anodes, cathodes} = pat(2);
    edges(10);
    chk("glitch pos", {29'd0, pos}, 32'd2);
    chk("glitch valid", {31'd0, pos_valid}, 32'd1);
    chk("glitch steps", n_step - b_s, 32'd0);
    chk("glitch errs", n_errp - b_e, 32'd0);
    chk("glitch frame", seg_frame, exp_frame);

    // illegal pattern
    anodes = 4'b0011; cathodes = 8'hA3;
    edges(6);
    chk("ill early err", {31'd0, err}, 32'd0);
    edges(1);
    chk("ill err", {31'd0, err}, 32'd1);
    chk("ill valid", {31'd0, pos_valid}, 32'd0);
    chk("ill blank", {31'd0, blank}, 32'd0);
    chk("ill errcnt", {24'd0, err_count}, 32'd1);
    edges(1);
    chk("ill err off", {31'd0, err}, 32'd0);
    edges(2);
    move(4, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, "after ill");
    move(0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, "jump");
    chk("jump errcnt", {24'd0, err_count}, 32'd2);

    // blank and frame
    move(1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "bf1");
    anodes = 4'hF; cathodes = 8'h5A;
    edges(7);
    chk("blank blank", {31'd0, blank}, 32'd1);
    chk("blank valid", {31'd0, pos_valid}, 32'd0);
    chk("blank digit1", {24'd0, seg_frame[23:16]}, 32'hA3);
    chk("blank frame", seg_frame, exp_frame);
    edges(3);
    move(4, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, "from blank");

    // error counter saturation
    b_e = n_errp;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) begin anodes = 4'b0011; cathodes = 8'hA3; end
      else begin anodes = 4'b0000; cathodes = 8'h00; end
      edges(6);
    end
    edges(2);
    chk("sat errs", n_errp - b_e, 32'd300);
    chk("sat errcnt", {24'd0, err_count}, 32'd255);

    // reset mid-track at pos 5
    move(6, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, "pre6");
    move(5, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, "pre5");
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst pos", {29'd0, pos}, 32'd0);
    chk("mid rst valid", {31'd0, pos_valid}, 32'd0);
    chk("mid rst blank", {31'd0, blank}, 32'd1);
    chk("mid rst dir", {31'd0, dir_cw}, 32'd1);
    chk("mid rst errcnt", {24'd0, err_count}, 32'd0);
    chk("mid rst frame", seg_frame, 32'hFFFF_FFFF);
    edges(2);
    rst = 1'b0;
    b_s = n_step;
    edges(6);
    chk("post rst early", {31'd0, pos_valid}, 32'd0);
    edges(4);
    chk("post rst valid", {31'd0, pos_valid}, 32'd1);
    chk("post rst pos", {29'd0, pos}, 32'd5);
    chk("post rst steps", n_step - b_s, 32'd0);
    chk("post rst frame", seg_frame, 32'hFFFF_9CFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
